// File: rtl/mult_pkg.sv
// Shared multiplier types, test-vector struct and Wallace-tree sizing helpers.
package mult_pkg;

   localparam int unsigned MultWidth = 4;

   typedef logic [MultWidth-1:0]   multiplicand_t;
   typedef logic [2*MultWidth-1:0] product_t;

   typedef struct packed {
      multiplicand_t multiplicand;
      multiplicand_t multiplier;
      product_t      expected;
   } mult_vec_t;

   // Row count after a number of 3:2 layers: each group of three rows becomes two.
   function automatic int unsigned wallace_rows(int unsigned n, int unsigned layer);
      int unsigned c;
      c = n;
      for (int unsigned i = 0; i < layer; i++) begin
         c = 2 * (c / 3) + (c % 3);
      end
      return c;
   endfunction

   function automatic int unsigned wallace_layers(int unsigned n);
      int unsigned c;
      int unsigned l;
      c = n;
      l = 0;
      while (c > 2) begin
         c = 2 * (c / 3) + (c % 3);
         l++;
      end
      return l;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; used as a half adder with cin_i tied low.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/wallace_mult_reg.sv
// Unsigned Width x Width multiplier: Wallace 3:2 reduction of partial products, ripple final add,
// registered product with one-cycle latency.
module wallace_mult_reg
   import mult_pkg::*;
#(
   parameter int unsigned Width = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic [Width-1:0]     data_in1_i,
   input  logic [Width-1:0]     data_in2_i,
   output logic                 valid_o,
   output logic [2*Width-1:0]   data_out_o
);

   localparam int unsigned PW        = 2 * Width;
   localparam int unsigned NumLayers = wallace_layers(Width);

   typedef logic [PW-1:0] prod_t;

   // rows[l] holds the operand rows entering layer l; unused slots are tied to zero.
   prod_t rows [NumLayers+1][Width];

   for (genvar j = 0; j < Width; j++) begin : g_pp
      assign rows[0][j] = prod_t'(data_in1_i & {Width{data_in2_i[j]}}) << j;
   end

   for (genvar l = 0; l < NumLayers; l++) begin : g_layer
      localparam int unsigned NIn  = wallace_rows(Width, l);
      localparam int unsigned NGrp = NIn / 3;
      localparam int unsigned NOut = 2 * NGrp + (NIn % 3);

      for (genvar g = 0; g < NGrp; g++) begin : g_csa
         prod_t sum;
         prod_t cry;
         for (genvar b = 0; b < PW; b++) begin : g_bit
            full_adder u_fa (
               .a_i    (rows[l][3*g][b]),
               .b_i    (rows[l][3*g+1][b]),
               .cin_i  (rows[l][3*g+2][b]),
               .sum_o  (sum[b]),
               .cout_o (cry[b])
            );
         end
         // Carry out of the top column is always zero since the product fits in PW bits.
         assign rows[l+1][2*g]   = sum;
         assign rows[l+1][2*g+1] = {cry[PW-2:0], 1'b0};
      end

      for (genvar r = 2 * NGrp; r < Width; r++) begin : g_pass
         if (r < NOut) begin : g_fwd
            assign rows[l+1][r] = rows[l][r+NGrp];
         end else begin : g_zero
            assign rows[l+1][r] = '0;
         end
      end
   end

   prod_t            op_a;
   prod_t            op_b;
   prod_t            sum_fin;
   logic  [PW:0]     carry;

   assign op_a     = rows[NumLayers][0];
   assign op_b     = rows[NumLayers][1];
   assign carry[0] = 1'b0;

   for (genvar b = 0; b < PW; b++) begin : g_rca
      full_adder u_fa (
         .a_i    (op_a[b]),
         .b_i    (op_b[b]),
         .cin_i  (carry[b]),
         .sum_o  (sum_fin[b]),
         .cout_o (carry[b+1])
      );
   end

   prod_t data_q, data_d;
   logic  valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_i;
      if (valid_i) begin
         data_d = sum_fin;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out_o = data_q;
   assign valid_o    = valid_q;

endmodule

// File: tb/tb_wallace_mult_reg.sv
// Bench for wallace_mult_reg at Width=4 (directed + exhaustive) and Width=8 (random).
module tb_wallace_mult_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v4, vo4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        v8, vo8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int total = 0;
   int bad   = 0;

   // Reference state: what each DUT output should hold after the latest edge.
   logic [7:0]  m4;
   logic        mv4;
   logic [15:0] m8;
   logic        mv8;

   wallace_mult_reg #(.Width(4)) u_dut4 (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (v4),
      .data_in1_i (a4),
      .data_in2_i (b4),
      .valid_o    (vo4),
      .data_out_o (p4)
   );

   wallace_mult_reg #(.Width(8)) u_dut8 (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (v8),
      .data_in1_i (a8),
      .data_in2_i (b8),
      .valid_o    (vo8),
      .data_out_o (p8)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic v,
                       input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      rst = r;
      v4  = v;
      a4  = a;
      b4  = b;
      v8  = v;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      @(posedge clk);
      if (r) begin
         m4  = '0;
         mv4 = 1'b0;
         m8  = '0;
         mv8 = 1'b0;
      end else begin
         mv4 = v;
         mv8 = v;
         if (v) begin
            m4 = 8'(int'(a) * int'(b));
            m8 = 16'(int'(a8) * int'(b8));
         end
      end
      #1;
      chk({tag, " w4 data"},  16'(p4),  16'(m4));
      chk({tag, " w4 valid"}, 16'(vo4), 16'(mv4));
      chk({tag, " w8 data"},  p8,       m8);
      chk({tag, " w8 valid"}, 16'(vo8), 16'(mv8));
   endtask

   initial begin
      rst = 1'b1;
      v4  = 1'b0;
      a4  = '0;
      b4  = '0;
      v8  = 1'b0;
      a8  = '0;
      b8  = '0;
      m4  = '0;
      mv4 = 1'b0;
      m8  = '0;
      mv8 = 1'b0;

      step("reset0", 1'b1, 1'b0, 4'd0, 4'd0);
      step("reset1", 1'b1, 1'b1, 4'd9, 4'd9);

      step("2x7",   1'b0, 1'b1, 4'd2,  4'd7);
      step("13x6",  1'b0, 1'b1, 4'd13, 4'd6);
      step("5x14",  1'b0, 1'b1, 4'd5,  4'd14);
      step("11x1",  1'b0, 1'b1, 4'd11, 4'd1);
      step("0x0",   1'b0, 1'b1, 4'd0,  4'd0);
      step("0x5",   1'b0, 1'b1, 4'd0,  4'd5);
      step("15x15", 1'b0, 1'b1, 4'd15, 4'd15);

      step("b2b 2x7",   1'b0, 1'b1, 4'd2,  4'd7);
      step("b2b 13x6",  1'b0, 1'b1, 4'd13, 4'd6);
      step("b2b 15x15", 1'b0, 1'b1, 4'd15, 4'd15);

      step("pre-rst 15x15", 1'b0, 1'b1, 4'd15, 4'd15);
      step("rst mid-op",    1'b1, 1'b1, 4'd15, 4'd15);
      step("post-rst 5x14", 1'b0, 1'b1, 4'd5,  4'd14);

      step("hold load 13x6", 1'b0, 1'b1, 4'd13, 4'd6);
      step("hold idle",      1'b0, 1'b0, 4'd0,  4'd0);
      step("hold idle2",     1'b0, 1'b0, 4'd3,  4'd3);

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            step("exhaustive", 1'b0, 1'b1, 4'(i), 4'(j));
         end
      end

      for (int k = 0; k < 200; k++) begin
         step("random", 1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
